// File: rtl/rv32i_wb_pkg.sv
// Shared types and default sizes for the RV32I register-file writeback path.
package rv32i_wb_pkg;

  localparam int DEF_NUM_OF_SETS    = 32;
  localparam int DEF_DATA_BUS_WIDTH = 32;
  localparam int DEF_MEM_FIFO_DEPTH = 4;
  localparam int WB_ADDR_W          = $clog2(DEF_NUM_OF_SETS);
  localparam int WB_DATA_W          = DEF_DATA_BUS_WIDTH;

  typedef struct packed {
    logic [WB_ADDR_W-1:0] rd;
    logic [WB_DATA_W-1:0] data;
  } wb_result_t;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_ALU,
    SRC_MEM
  } wb_src_e;

endpackage

// File: rtl/rv32i_wb_fifo.sv
// Small FIFO of mem/load results; head is visible combinationally for arbitration.
module rv32i_wb_fifo
  import rv32i_wb_pkg::*;
#(
  parameter int DEPTH = DEF_MEM_FIFO_DEPTH
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  wb_result_t push_data,
  input  logic       pop,
  output wb_result_t head,
  output logic       full,
  output logic       empty
);

  localparam int PW = $clog2(DEPTH);

  logic [PW:0] wr_ptr_reg;
  logic [PW:0] rd_ptr_reg;
  wb_result_t  mem_reg [DEPTH];
  logic        do_push;
  logic        do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + (PW+1)'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + (PW+1)'(1);
    end
  end

  // Storage carries no reset so it can map onto distributed RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem_reg[wr_ptr_reg[PW-1:0]] <= push_data;
  end

  assign head  = mem_reg[rd_ptr_reg[PW-1:0]];
  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[PW] != rd_ptr_reg[PW]) &&
                 (wr_ptr_reg[PW-1:0] == rd_ptr_reg[PW-1:0]);

endmodule

// File: rtl/rv32i_writeback_arbiter.sv
// Merges ALU and buffered mem results onto the register-file write port and
// tracks outstanding destinations for decode's RAW stall.
module rv32i_writeback_arbiter
  import rv32i_wb_pkg::*;
#(
  parameter int NUM_OF_SETS    = DEF_NUM_OF_SETS,
  parameter int DATA_BUS_WIDTH = DEF_DATA_BUS_WIDTH,
  parameter int MEM_FIFO_DEPTH = DEF_MEM_FIFO_DEPTH,
  localparam int A             = $clog2(NUM_OF_SETS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      issue_valid,
  input  logic [A-1:0]              issue_rd,
  input  logic                      alu_valid,
  input  logic [A-1:0]              alu_rd,
  input  logic [DATA_BUS_WIDTH-1:0] alu_data,
  output logic                      alu_ready,
  input  logic                      mem_valid,
  input  logic [A-1:0]              mem_rd,
  input  logic [DATA_BUS_WIDTH-1:0] mem_data,
  output logic                      mem_ready,
  output logic                      wr_enable,
  output logic [A-1:0]              wr_addr,
  output logic [DATA_BUS_WIDTH-1:0] wr_data,
  output logic [NUM_OF_SETS-1:0]    pending,
  output logic                      fifo_full
);

  wb_src_e    src;
  wb_result_t win;
  wb_result_t fifo_head;
  logic       fifo_empty;
  logic       fifo_push;
  logic       fifo_pop;

  logic                      wr_enable_reg;
  logic [A-1:0]              wr_addr_reg;
  logic [DATA_BUS_WIDTH-1:0] wr_data_reg;
  logic [NUM_OF_SETS-1:0]    pending_reg;
  logic [NUM_OF_SETS-1:0]    pending_next;

  rv32i_wb_fifo #(
    .DEPTH (MEM_FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (wb_result_t'{rd: mem_rd, data: mem_data}),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // A full FIFO preempts the ALU so mem results cannot starve.
  always_comb begin
    src       = SRC_NONE;
    win       = '0;
    alu_ready = !(fifo_full && !fifo_empty);
    if (fifo_full && !fifo_empty) src = SRC_MEM;
    else if (alu_valid)           src = SRC_ALU;
    else if (!fifo_empty)         src = SRC_MEM;
    case (src)
      SRC_ALU: win = wb_result_t'{rd: alu_rd, data: alu_data};
      SRC_MEM: win = fifo_head;
      default: win = '0;
    endcase
  end

  assign mem_ready = !fifo_full;
  assign fifo_push = mem_valid && mem_ready;
  assign fifo_pop  = (src == SRC_MEM);

  // x0 winners are consumed upstream but never reach the write port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_enable_reg <= 1'b0;
      wr_addr_reg   <= '0;
      wr_data_reg   <= '0;
    end else begin
      wr_enable_reg <= (src != SRC_NONE) && (win.rd != '0);
      if ((src != SRC_NONE) && (win.rd != '0)) begin
        wr_addr_reg <= win.rd;
        wr_data_reg <= win.data;
      end
    end
  end

  // Set beats clear so a re-issue on the retiring edge stays pending.
  assign pending_next[0] = 1'b0;
  for (genvar gi = 1; gi < NUM_OF_SETS; gi++) begin : g_pending
    always_comb begin
      pending_next[gi] = pending_reg[gi];
      if (wr_enable_reg && (wr_addr_reg == A'(gi))) pending_next[gi] = 1'b0;
      if (issue_valid && (issue_rd == A'(gi)))      pending_next[gi] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pending_reg <= '0;
    else     pending_reg <= pending_next;
  end

  assign wr_enable = wr_enable_reg;
  assign wr_addr   = wr_addr_reg;
  assign wr_data   = wr_data_reg;
  assign pending   = pending_reg;

endmodule

// File: tb/tb_rv32i_writeback_arbiter.sv
// Scoreboard bench: queue-based reference model predicts writes, readys and pending bits.
module tb_rv32i_writeback_arbiter;

  localparam int NS    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int A     = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          issue_valid;
  logic [A-1:0]  issue_rd;
  logic          alu_valid;
  logic [A-1:0]  alu_rd;
  logic [DW-1:0] alu_data;
  logic          alu_ready;
  logic          mem_valid;
  logic [A-1:0]  mem_rd;
  logic [DW-1:0] mem_data;
  logic          mem_ready;
  logic          wr_enable;
  logic [A-1:0]  wr_addr;
  logic [DW-1:0] wr_data;
  logic [NS-1:0] pending;
  logic          fifo_full;

  rv32i_writeback_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .alu_valid   (alu_valid),
    .alu_rd      (alu_rd),
    .alu_data    (alu_data),
    .alu_ready   (alu_ready),
    .mem_valid   (mem_valid),
    .mem_rd      (mem_rd),
    .mem_data    (mem_data),
    .mem_ready   (mem_ready),
    .wr_enable   (wr_enable),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .pending     (pending),
    .fifo_full   (fifo_full)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [A-1:0]  rd;
    logic [DW-1:0] data;
  } res_t;

  res_t          fifo_m[$];
  res_t          exp_q[$];
  logic [NS-1:0] pend_m;
  bit            lw_valid;
  logic [A-1:0]  lw_rd;
  int            n_cmp = 0;
  int            n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Monitor: every visible write must match the oldest predicted write.
  always @(negedge clk) begin
    res_t e;
    if (rst === 1'b0 && wr_enable === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_write: got x%0d=%h, expected no write", wr_addr, wr_data);
      end else begin
        e = exp_q.pop_front();
        $display("write x%0d <= %h (expected x%0d <= %h)", wr_addr, wr_data, e.rd, e.data);
        chk("wr_addr", 64'(wr_addr), 64'(e.rd));
        chk("wr_data", 64'(wr_data), 64'(e.data));
      end
    end
  end

  // One cycle: check state-derived outputs, then advance the reference model.
  task automatic tick();
    bit   full;
    bit   wv;
    res_t w;
    @(negedge clk);
    full = (fifo_m.size() == DEPTH);
    chk("alu_ready", 64'(alu_ready), 64'(!full));
    chk("mem_ready", 64'(mem_ready), 64'(!full));
    chk("fifo_full", 64'(fifo_full), 64'(full));
    chk("pending",   64'(pending),   64'(pend_m));
    wv = 1'b0;
    w  = '0;
    if (full) begin
      w = fifo_m.pop_front(); wv = 1'b1;
    end else if (alu_valid) begin
      w.rd = alu_rd; w.data = alu_data; wv = 1'b1;
    end else if (fifo_m.size() > 0) begin
      w = fifo_m.pop_front(); wv = 1'b1;
    end
    if (mem_valid && !full) fifo_m.push_back('{rd: mem_rd, data: mem_data});
    if (fifo_m.size() > DEPTH) begin
      n_cmp++; n_err++;
      $display("FAIL fifo_overflow: got %0d entries, expected at most %0d", fifo_m.size(), DEPTH);
    end
    if (lw_valid) pend_m[lw_rd] = 1'b0;
    if (issue_valid && issue_rd != '0) pend_m[issue_rd] = 1'b1;
    lw_valid = wv && (w.rd != '0);
    lw_rd    = w.rd;
    if (lw_valid) exp_q.push_back(w);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    issue_valid = 1'b0; issue_rd = '0;
    alu_valid   = 1'b0; alu_rd   = '0; alu_data = '0;
    mem_valid   = 1'b0; mem_rd   = '0; mem_data = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    #2;
    chk("rst_wr_enable", 64'(wr_enable), 64'd0);
    chk("rst_wr_addr",   64'(wr_addr),   64'd0);
    chk("rst_wr_data",   64'(wr_data),   64'd0);
    chk("rst_pending",   64'(pending),   64'd0);
    chk("rst_fifo_full", 64'(fifo_full), 64'd0);
    chk("rst_mem_ready", 64'(mem_ready), 64'd1);
    fifo_m.delete();
    exp_q.delete();
    pend_m   = '0;
    lw_valid = 1'b0;
    lw_rd    = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    do_reset();

    // Reset while the FIFO holds three mem results behind a busy ALU.
    for (int i = 0; i < 3; i++) begin
      alu_valid = 1'b1; alu_rd = A'(10 + i); alu_data = $urandom;
      mem_valid = 1'b1; mem_rd = A'(1 + i);  mem_data = $urandom;
      issue_valid = 1'b1; issue_rd = A'(1 + i);
      tick();
    end
    do_reset();
    tick();

    // Single ALU write.
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    tick();
    idle_inputs();
    tick();

    // ALU write to x0 is consumed silently.
    alu_valid = 1'b1; alu_rd = '0; alu_data = 32'h0000_1234;
    tick();
    idle_inputs();
    tick();
    tick();

    // Contention: ALU every cycle, four mem results fill the FIFO.
    for (int i = 0; i < 12; i++) begin
      alu_valid = 1'b1; alu_rd = A'(20 + i % 8); alu_data = $urandom;
      mem_valid = (i < 4); mem_rd = A'(i + 1); mem_data = 32'h1000_0000 + i;
      tick();
    end
    idle_inputs();
    for (int i = 0; i < 6; i++) tick();

    // Scoreboard: pending[7] set by issue, re-issued on the retiring edge.
    issue_valid = 1'b1; issue_rd = 5'd7;
    tick();
    idle_inputs();
    mem_valid = 1'b1; mem_rd = 5'd7; mem_data = 32'hA5A5A5A5;
    tick();
    idle_inputs();
    tick();
    issue_valid = 1'b1; issue_rd = 5'd7;
    tick();
    idle_inputs();
    tick();
    chk("pending7_kept", 64'(pending[7]), 64'd1);
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h0BAD_F00D;
    tick();
    idle_inputs();
    tick();
    tick();
    chk("pending7_cleared", 64'(pending[7]), 64'd0);

    // Constrained-random traffic.
    for (int i = 0; i < 800; i++) begin
      alu_valid   = ($urandom_range(99) < 50);
      alu_rd      = A'($urandom_range(NS - 1));
      alu_data    = $urandom;
      mem_valid   = ($urandom_range(99) < 45);
      mem_rd      = A'($urandom_range(NS - 1));
      mem_data    = $urandom;
      issue_valid = ($urandom_range(99) < 30);
      issue_rd    = A'($urandom_range(NS - 1));
      tick();
    end
    idle_inputs();
    for (int i = 0; i < 10; i++) tick();
    chk("exp_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
